// File: rtl/strobe_handshake_pkg.sv
// Shared constants and types for the toggle-based strobe handshake.
// The synchronizer vector is sized for the deepest legal chain; shallower chains mask the upper bits.
package strobe_handshake_pkg;

  localparam int unsigned DEFAULT_SYNC_STAGES = 2;
  localparam int unsigned MAX_SYNC_STAGES     = 4;

  typedef logic [MAX_SYNC_STAGES-1:0] sync_vec_t;

  // Bits [stages-1:0] set: the live part of a synchronizer vector.
  function automatic sync_vec_t stage_mask(input int unsigned stages);
    sync_vec_t m;
    m = '0;
    for (int unsigned i = 0; i < MAX_SYNC_STAGES; i++) begin
      if (i < stages) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/strobe_handshake_sync_sync_bit.sv
// Single-bit synchronizer chain of SYNC_STAGES flops with asynchronous active-high reset.
// q is the last stage; it follows d after SYNC_STAGES rising edges.
module sync_bit
  import strobe_handshake_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  sync_vec_t chain;

  // Unused upper stages are forced to zero so a shorter chain behaves exactly as its own width.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chain <= '0;
    end else begin
      chain <= ((chain << 1) | sync_vec_t'(d)) & stage_mask(SYNC_STAGES);
    end
  end

  assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/strobe_handshake_sync.sv
// Toggle-based strobe handshake: source strobe -> request toggle -> sync -> dest strobe,
// with an acknowledge toggle synchronized back to release the source stall.
module strobe_handshake_sync
  import strobe_handshake_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic clk,
  input  logic reset,
  input  logic source_strobe,
  output logic source_stall,
  input  logic dest_stall,
  output logic dest_strobe,
  output logic source_overrun
);

  logic req_tgl;
  logic req_last;
  logic req_seen;
  logic ack_tgl;
  logic ack_last;
  logic accept;
  logic pending;

  assign accept  = source_strobe & ~source_stall;
  assign pending = req_last ^ req_seen;

  sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_req_sync (
    .clk   (clk),
    .reset (reset),
    .d     (req_tgl),
    .q     (req_last)
  );

  sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_ack_sync (
    .clk   (clk),
    .reset (reset),
    .d     (ack_tgl),
    .q     (ack_last)
  );

  // Source side: the stall drops once the returned acknowledge matches the request toggle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_tgl        <= 1'b0;
      source_stall   <= 1'b0;
      source_overrun <= 1'b0;
    end else begin
      if (accept) begin
        req_tgl      <= ~req_tgl;
        source_stall <= 1'b1;
      end else if (source_stall && (ack_last == req_tgl)) begin
        source_stall <= 1'b0;
      end
      if (source_strobe && source_stall) begin
        source_overrun <= 1'b1;
      end
    end
  end

  // Destination side: a pending request waits here for as long as dest_stall holds it off.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_seen    <= 1'b0;
      ack_tgl     <= 1'b0;
      dest_strobe <= 1'b0;
    end else begin
      dest_strobe <= 1'b0;
      if (pending && !dest_stall) begin
        dest_strobe <= 1'b1;
        req_seen    <= req_last;
        ack_tgl     <= ~ack_tgl;
      end
    end
  end

endmodule

// File: tb/tb_strobe_handshake_sync.sv
// Scoreboard bench: each accepted strobe pushes its expected delivery edge; dest_strobe pops and compares.
// A second instance with SYNC_STAGES=3 checks the deeper-chain latency and stall length.
module tb_strobe_handshake_sync;

  localparam int unsigned S  = 2;
  localparam int unsigned S2 = 3;

  logic clk = 1'b0;
  logic reset;
  logic strobe, dstall, stall, dstrobe, overrun;
  logic strobe2, dstall2, stall2, dstrobe2, overrun2;

  int unsigned cyc = 0;
  int checks = 0;
  int errors = 0;
  int unsigned q1[$];
  int unsigned q2[$];
  int deliveries1 = 0;
  int deliveries2 = 0;
  logic prev1 = 1'b0;
  logic prev2 = 1'b0;

  strobe_handshake_sync #(.SYNC_STAGES(S)) dut (
    .clk            (clk),
    .reset          (reset),
    .source_strobe  (strobe),
    .source_stall   (stall),
    .dest_stall     (dstall),
    .dest_strobe    (dstrobe),
    .source_overrun (overrun)
  );

  strobe_handshake_sync #(.SYNC_STAGES(S2)) dut3 (
    .clk            (clk),
    .reset          (reset),
    .source_strobe  (strobe2),
    .source_stall   (stall2),
    .dest_stall     (dstall2),
    .dest_strobe    (dstrobe2),
    .source_overrun (overrun2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  task automatic wait_cyc(input int unsigned n);
    while (cyc < n) @(negedge clk);
  endtask

  // Drive a one-cycle strobe so that it is sampled at edge e.
  task automatic pulse(input int unsigned e, input bit both);
    wait_cyc(e - 1);
    strobe  = 1'b1;
    strobe2 = both;
    @(negedge clk);
    strobe  = 1'b0;
    strobe2 = 1'b0;
  endtask

  always @(negedge clk) begin
    if (reset) begin
      prev1 = 1'b0;
    end else begin
      if (dstrobe) begin
        deliveries1++;
        check("isolated", int'(prev1), 0);
        check("queue_nonempty", int'(q1.size() != 0), 1);
        if (q1.size() != 0) check("deliver_cycle", int'(cyc), int'(q1.pop_front()));
      end
      prev1 = dstrobe;
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      prev2 = 1'b0;
    end else begin
      if (dstrobe2) begin
        deliveries2++;
        check("s3_isolated", int'(prev2), 0);
        check("s3_queue_nonempty", int'(q2.size() != 0), 1);
        if (q2.size() != 0) check("s3_deliver_cycle", int'(cyc), int'(q2.pop_front()));
      end
      prev2 = dstrobe2;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned base, c, d;
    reset = 1'b1; strobe = 1'b0; dstall = 1'b0; strobe2 = 1'b0; dstall2 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_stall", int'(stall), 0);
    check("rst_dstrobe", int'(dstrobe), 0);
    check("rst_overrun", int'(overrun), 0);
    check("rst_s3_stall", int'(stall2), 0);
    reset = 1'b0;

    // Single transfer, no back-pressure; both instances.
    q1.push_back(10 + S + 1);
    q2.push_back(10 + S2 + 1);
    pulse(10, 1'b1);
    check("stall_on", int'(stall), 1);
    wait_cyc(10 + 2*S + 1);  check("stall_last", int'(stall), 1);
    wait_cyc(10 + 2*S + 2);  check("stall_off", int'(stall), 0);
    check("no_overrun", int'(overrun), 0);
    wait_cyc(10 + 2*S2 + 1); check("s3_stall_last", int'(stall2), 1);
    wait_cyc(10 + 2*S2 + 2); check("s3_stall_off", int'(stall2), 0);

    // Back-pressure sampled on edges 30..40; delivery at edge 41, release S+1 edges later.
    wait_cyc(29);
    dstall = 1'b1;
    strobe = 1'b1;
    q1.push_back(41);
    @(negedge clk);
    strobe = 1'b0;
    wait_cyc(40);
    check("held_count", deliveries1, 1);
    dstall = 1'b0;
    wait_cyc(41 + S);     check("bp_stall_last", int'(stall), 1);
    wait_cyc(41 + S + 1); check("bp_stall_off", int'(stall), 0);

    // Five back-to-back transfers, each strobed in the first cycle stall reads 0.
    base = deliveries1;
    for (int k = 0; k < 5; k++) begin
      int guard = 0;
      while (stall && guard < 50) begin
        @(negedge clk);
        guard++;
      end
      check("b2b_ready", int'(stall), 0);
      q1.push_back(cyc + 1 + S + 1);
      strobe = 1'b1;
      @(negedge clk);
      strobe = 1'b0;
    end
    repeat (12) @(negedge clk);
    check("b2b_count", deliveries1, int'(base) + 5);
    check("b2b_overrun", int'(overrun), 0);

    // Second strobe while stalled: ignored, overrun sticky.
    base = deliveries1;
    c = cyc + 5;
    q1.push_back(c + S + 1);
    pulse(c, 1'b0);
    wait_cyc(c + 1);
    check("ovr_before", int'(overrun), 0);
    strobe = 1'b1;
    @(negedge clk);
    strobe = 1'b0;
    check("ovr_set", int'(overrun), 1);
    wait_cyc(c + 15);
    check("ovr_sticky", int'(overrun), 1);
    check("ovr_one_delivery", deliveries1, int'(base) + 1);
    reset = 1'b1;
    #1;
    check("ovr_cleared", int'(overrun), 0);
    @(negedge clk);
    reset = 1'b0;

    // Reset with a transfer in flight: discarded on both instances.
    d = cyc + 3;
    pulse(d, 1'b1);
    wait_cyc(d + 2);
    reset = 1'b1;
    #1;
    check("mid_rst_stall", int'(stall), 0);
    check("mid_rst_dstrobe", int'(dstrobe), 0);
    check("mid_rst_s3_stall", int'(stall2), 0);
    q1.delete();
    q2.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    base = deliveries1;
    repeat (20) @(negedge clk);
    check("no_ghost", deliveries1, int'(base));
    check("s3_total", deliveries2, 1);
    check("drain", q1.size() + q2.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
